// File: rtl/address_multiply_sequencer_pkg.sv
// Shared definitions for the address multiply issue/retire stage.
// Contents: legal opcodes, A-register index width, default pipe depth and
// a small opcode-legality helper.
package address_multiply_sequencer_pkg;

  localparam int NREG_DEF = 8;
  localparam int AIDX_W   = $clog2(NREG_DEF);
  localparam int LAT_DEF  = 7;
  localparam int CNT_W    = 4;

  localparam logic [6:0] OP_AMUL_A = 7'o022;
  localparam logic [6:0] OP_AMUL_B = 7'o023;

  function automatic logic is_amul_op(input logic [6:0] op);
    return (op == OP_AMUL_A) || (op == OP_AMUL_B);
  endfunction

endpackage

// File: rtl/amul_tag_pipe.sv
// Destination-tag shadow pipe: LAT stages of {valid, index} that advance
// every cycle in lockstep with a free-running functional unit.
// Ports:
//   clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid, i_idx    tag entering stage 0 at each rising edge
//   o_valid, o_idx    tag at stage LAT-1 (aligned with the FU result)
module amul_tag_pipe #(
  parameter int LAT   = 7,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [LAT-1:0]   vld_q;
  logic [IDX_W-1:0] idx_q [LAT];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= i_valid;
      idx_q[0] <= i_idx;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign o_valid = vld_q[LAT-1];
  assign o_idx   = idx_q[LAT-1];

endmodule

// File: rtl/address_multiply_sequencer.sv
// Issue/retire control around the external 32-bit address multiply unit.
// Accepts 022/023 instructions when none of the three A registers is
// reserved (here or elsewhere), hands the operands to the FU, shadows the
// destination through the FU depth and writes the product back.
// Ports:
//   clk, i_rst_n                 clock, asynchronous active-low reset
//   i_issue_valid, i_opcode      offered instruction
//   i_ai, i_aj, i_ak             destination / source indices
//   i_Aj_val, i_Ak_val           source values read at issue
//   i_ext_busy                   reservations held by other units
//   o_issue_ready                instruction accepted this cycle
//   o_illegal                    registered pulse for an illegal offer
//   o_fu_Aj, o_fu_Ak, i_fu_Ai    FU operand and product buses
//   o_wb_valid/addr/data         A-register write port
//   o_busy, o_inflight           reservations and in-flight count
module address_multiply_sequencer
  import address_multiply_sequencer_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int LAT  = LAT_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_issue_valid,
  input  logic [6:0]        i_opcode,
  input  logic [AIDX_W-1:0] i_ai,
  input  logic [AIDX_W-1:0] i_aj,
  input  logic [AIDX_W-1:0] i_ak,
  input  logic [SIZE-1:0]   i_Aj_val,
  input  logic [SIZE-1:0]   i_Ak_val,
  input  logic [NREG-1:0]   i_ext_busy,
  output logic              o_issue_ready,
  output logic              o_illegal,
  output logic [SIZE-1:0]   o_fu_Aj,
  output logic [SIZE-1:0]   o_fu_Ak,
  input  logic [SIZE-1:0]   i_fu_Ai,
  output logic              o_wb_valid,
  output logic [AIDX_W-1:0] o_wb_addr,
  output logic [SIZE-1:0]   o_wb_data,
  output logic [NREG-1:0]   o_busy,
  output logic [CNT_W-1:0]  o_inflight
);

  logic              legal;
  logic              hazard;
  logic              accept;
  logic [NREG-1:0]   busy_all;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              illegal_q;
  logic              wb_valid_q;
  logic [AIDX_W-1:0] wb_addr_q;
  logic [SIZE-1:0]   wb_data_q;
  logic              tag_vld;
  logic [AIDX_W-1:0] tag_idx;

  assign legal    = is_amul_op(i_opcode);
  assign busy_all = busy_q | i_ext_busy;
  // No bypass: a register being written this cycle is still reserved, so
  // a dependent or same-destination issue waits until the next cycle.
  assign hazard   = busy_all[i_ai] | busy_all[i_aj] | busy_all[i_ak];
  assign accept   = i_issue_valid & legal & ~hazard;

  assign o_issue_ready = accept;
  assign o_fu_Aj       = accept ? i_Aj_val : '0;
  assign o_fu_Ak       = accept ? i_Ak_val : '0;

  amul_tag_pipe #(
    .LAT   (LAT),
    .IDX_W (AIDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_valid (accept),
    .i_idx   (i_ai),
    .o_valid (tag_vld),
    .o_idx   (tag_idx)
  );

  // Set and clear never hit the same index: the written register is still
  // busy, so it cannot be accepted as a destination in its write cycle.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_q) busy_d[wb_addr_q] = 1'b0;
    if (accept)     busy_d[i_ai]      = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, wb_valid_q})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= '0;
      inflight_q <= '0;
      illegal_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      illegal_q  <= i_issue_valid & ~legal;
      wb_valid_q <= tag_vld;
      wb_addr_q  <= tag_idx;
      // FU output is meaningless without a valid tag; keep the bus quiet.
      wb_data_q  <= tag_vld ? i_fu_Ai : '0;
    end
  end

  assign o_busy     = busy_q;
  assign o_inflight = inflight_q;
  assign o_illegal  = illegal_q;
  assign o_wb_valid = wb_valid_q;
  assign o_wb_addr  = wb_addr_q;
  assign o_wb_data  = wb_data_q;

endmodule

// File: tb/tb_address_multiply_sequencer.sv
module tb_address_multiply_sequencer;
  import address_multiply_sequencer_pkg::*;

  localparam int SIZE   = 32;
  localparam int LAT    = 7;
  localparam int NREG   = 8;
  localparam int WB_LAT = LAT + 1;

  logic            clk = 1'b0;
  logic            i_rst_n;
  logic            i_issue_valid;
  logic [6:0]      i_opcode;
  logic [2:0]      i_ai, i_aj, i_ak;
  logic [SIZE-1:0] i_Aj_val, i_Ak_val;
  logic [NREG-1:0] i_ext_busy;
  logic            o_issue_ready, o_illegal;
  logic [SIZE-1:0] o_fu_Aj, o_fu_Ak, i_fu_Ai;
  logic            o_wb_valid;
  logic [2:0]      o_wb_addr;
  logic [SIZE-1:0] o_wb_data;
  logic [NREG-1:0] o_busy;
  logic [3:0]      o_inflight;

  address_multiply_sequencer #(.SIZE(SIZE), .LAT(LAT), .NREG(NREG)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_issue_valid(i_issue_valid), .i_opcode(i_opcode),
    .i_ai(i_ai), .i_aj(i_aj), .i_ak(i_ak), .i_Aj_val(i_Aj_val), .i_Ak_val(i_Ak_val),
    .i_ext_busy(i_ext_busy), .o_issue_ready(o_issue_ready), .o_illegal(o_illegal),
    .o_fu_Aj(o_fu_Aj), .o_fu_Ak(o_fu_Ak), .i_fu_Ai(i_fu_Ai), .o_wb_valid(o_wb_valid),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_busy(o_busy), .o_inflight(o_inflight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Free-running FU model: operands captured mid-cycle, product appears LAT edges later.
  logic [SIZE-1:0] fu_in = '0;
  logic [SIZE-1:0] fu_pipe [LAT];
  always @(negedge clk) fu_in = o_fu_Aj * o_fu_Ak;
  always @(posedge clk) begin
    fu_pipe[0] <= fu_in;
    for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
  end
  assign i_fu_Ai = fu_pipe[LAT-1];

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
    int          c;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         wb_log[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] areg [NREG];
  int          rel_cyc [NREG];
  bit          prev_ill = 0;
  int          max_infl = 0;
  int          ill_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a register is reserved from the cycle after its accept
  // through its write cycle, i.e. while cyc <= accept_cycle + WB_LAT.
  logic [NREG-1:0] m_busy;
  int              m_n;
  bit              m_legal, m_haz, m_rdy;
  logic [31:0]     m_prod;
  always @(negedge clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) rel_cyc[r] = -1;
      exp_q.delete();
      prev_ill = 0;
      chk("rst_busy", o_busy, 0);
      chk("rst_inflight", o_inflight, 0);
      chk("rst_wb_valid", o_wb_valid, 0);
      chk("rst_wb_addr", o_wb_addr, 0);
      chk("rst_wb_data", o_wb_data, 0);
      chk("rst_illegal", o_illegal, 0);
      chk("rst_fu_aj", o_fu_Aj, 0);
      chk("rst_fu_ak", o_fu_Ak, 0);
    end else begin
      m_busy = '0;
      m_n    = 0;
      for (int r = 0; r < NREG; r++)
        if (cyc <= rel_cyc[r]) begin
          m_busy[r] = 1'b1;
          m_n++;
        end
      chk("busy", o_busy, m_busy);
      chk("inflight", o_inflight, m_n);
      if (int'(o_inflight) > max_infl) max_infl = int'(o_inflight);
      chk("illegal", o_illegal, prev_ill);
      if (o_illegal) ill_count++;
      m_legal = (i_opcode == 7'o022) || (i_opcode == 7'o023);
      m_haz   = m_busy[i_ai] || m_busy[i_aj] || m_busy[i_ak] ||
                i_ext_busy[i_ai] || i_ext_busy[i_aj] || i_ext_busy[i_ak];
      m_rdy   = i_issue_valid && m_legal && !m_haz;
      chk("issue_ready", o_issue_ready, m_rdy);
      chk("fu_aj", o_fu_Aj, m_rdy ? i_Aj_val : 32'd0);
      chk("fu_ak", o_fu_Ak, m_rdy ? i_Ak_val : 32'd0);
      prev_ill = i_issue_valid && !m_legal;
      if (m_rdy) begin
        m_prod = i_Aj_val * i_Ak_val;
        exp_q.push_back('{a: i_ai, d: m_prod, c: cyc + WB_LAT});
        rel_cyc[i_ai] = cyc + WB_LAT;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write.
  wb_t e;
  always @(negedge clk) begin
    if (i_rst_n && o_wb_valid) begin
      wb_log.push_back('{a: o_wb_addr, d: o_wb_data, c: cyc});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual addr=%0d data=%0h expected no write", o_wb_addr, o_wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", o_wb_addr, e.a);
        chk("wb_data", o_wb_data, e.d);
        chk("wb_cycle", cyc, e.c);
        areg[e.a] = e.d;
      end
    end
  end

  task automatic idle();
    i_issue_valid = 1'b0;
    i_opcode      = '0;
    i_ai          = '0;
    i_aj          = '0;
    i_ak          = '0;
    i_Aj_val      = '0;
    i_Ak_val      = '0;
    i_ext_busy    = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one instruction, holding it up to max_wait cycles until accepted.
  task automatic issue(input logic [6:0] op, input logic [2:0] ai, input logic [2:0] aj,
                       input logic [2:0] ak, input logic [31:0] ajv, input logic [31:0] akv,
                       input bit use_rf, input logic [7:0] ext, input int max_wait,
                       output bit acc, output int acc_cyc);
    acc     = 0;
    acc_cyc = -1;
    for (int w = 0; w < max_wait && !acc; w++) begin
      i_issue_valid = 1'b1;
      i_opcode      = op;
      i_ai          = ai;
      i_aj          = aj;
      i_ak          = ak;
      i_Aj_val      = use_rf ? areg[aj] : ajv;
      i_Ak_val      = use_rf ? areg[ak] : akv;
      i_ext_busy    = ext;
      @(negedge clk);
      acc = o_issue_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    idle();
  endtask

  bit          acc;
  int          c1, c2, n0;
  logic [31:0] p1, exp_raw;

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NREG; r++) areg[r] = $urandom;
    idle();
    i_rst_n = 1'b0;
    step(3);
    i_rst_n = 1'b1;
    step(1);

    // Single op: 7*6 into A3.
    issue(7'o022, 3'd3, 3'd0, 3'd1, 32'd7, 32'd6, 0, 8'h00, 1, acc, c1);
    chk("single_acc", acc, 1);
    step(12);
    chk("single_addr", wb_log[wb_log.size()-1].a, 3);
    chk("single_data", wb_log[wb_log.size()-1].d, 42);
    chk("single_wb_cycle", wb_log[wb_log.size()-1].c - c1, 8);
    chk("single_infl_end", o_inflight, 0);

    // Back-to-back issues to four distinct destinations.
    max_infl = 0;
    n0 = wb_log.size();
    issue(7'o023, 3'd1, 3'd6, 3'd7, 32'hFFFF_FFFF, 32'd2, 0, 8'h00, 1, acc, c1);
    chk("b2b_acc0", acc, 1);
    issue(7'o023, 3'd2, 3'd6, 3'd7, $urandom, $urandom, 0, 8'h00, 1, acc, c2);
    chk("b2b_acc1", acc, 1);
    issue(7'o023, 3'd4, 3'd6, 3'd7, $urandom, $urandom, 0, 8'h00, 1, acc, c2);
    chk("b2b_acc2", acc, 1);
    issue(7'o023, 3'd5, 3'd6, 3'd7, $urandom, $urandom, 0, 8'h00, 1, acc, c2);
    chk("b2b_acc3", acc, 1);
    step(12);
    chk("b2b_count", wb_log.size() - n0, 4);
    if (wb_log.size() - n0 == 4) begin
      chk("b2b_first_data", wb_log[n0].d, 32'hFFFF_FFFE);
      chk("b2b_addr1", wb_log[n0+1].a, 2);
      chk("b2b_addr2", wb_log[n0+2].a, 4);
      chk("b2b_addr3", wb_log[n0+3].a, 5);
      chk("b2b_consecutive", wb_log[n0+3].c - wb_log[n0].c, 3);
    end
    chk("b2b_peak", max_infl, 4);

    // RAW hazard: second op reads A2 written by the first.
    p1 = 32'd12345 * 32'd777;
    issue(7'o022, 3'd2, 3'd0, 3'd1, 32'd12345, 32'd777, 0, 8'h00, 1, acc, c1);
    chk("raw_acc0", acc, 1);
    issue(7'o022, 3'd7, 3'd2, 3'd4, 32'd0, 32'd0, 1, 8'h00, 20, acc, c2);
    chk("raw_acc1", acc, 1);
    chk("raw_stall", c2 - c1, 9);
    exp_raw = p1 * areg[4];
    step(12);
    chk("raw_data", wb_log[wb_log.size()-1].d, exp_raw);
    chk("raw_addr", wb_log[wb_log.size()-1].a, 7);

    // External reservation blocks, then releases.
    issue(7'o022, 3'd0, 3'd1, 3'd6, 32'd5, 32'd9, 0, 8'h40, 5, acc, c1);
    chk("ext_block", acc, 0);
    issue(7'o022, 3'd0, 3'd1, 3'd6, 32'd5, 32'd9, 0, 8'h00, 1, acc, c1);
    chk("ext_release", acc, 1);
    step(12);
    chk("ext_data", wb_log[wb_log.size()-1].d, 45);

    // Illegal opcode.
    n0 = wb_log.size();
    c2 = ill_count;
    issue(7'o024, 3'd3, 3'd0, 3'd1, 32'd1, 32'd1, 0, 8'h00, 1, acc, c1);
    chk("illegal_acc", acc, 0);
    step(3);
    chk("illegal_pulses", ill_count - c2, 1);
    chk("illegal_busy", o_busy, 0);
    step(10);
    chk("illegal_no_wb", wb_log.size() - n0, 0);

    // Asynchronous reset with two operations in flight.
    issue(7'o022, 3'd1, 3'd0, 3'd3, $urandom, $urandom, 0, 8'h00, 1, acc, c1);
    chk("rstmf_acc0", acc, 1);
    issue(7'o023, 3'd2, 3'd0, 3'd3, $urandom, $urandom, 0, 8'h00, 1, acc, c1);
    chk("rstmf_acc1", acc, 1);
    step(2);
    n0 = wb_log.size();
    i_rst_n = 1'b0;
    #1;
    chk("rstmf_busy", o_busy, 0);
    chk("rstmf_inflight", o_inflight, 0);
    chk("rstmf_wb_valid", o_wb_valid, 0);
    chk("rstmf_wb_data", o_wb_data, 0);
    step(2);
    i_rst_n = 1'b1;
    #1;
    chk("rstmf_busy_after", o_busy, 0);
    step(14);
    chk("rstmf_no_wb", wb_log.size() - n0, 0);
    issue(7'o022, 3'd3, 3'd4, 3'd5, 32'd9, 32'd11, 0, 8'h00, 1, acc, c1);
    chk("rstmf_new_acc", acc, 1);
    step(12);
    chk("rstmf_new_addr", wb_log[wb_log.size()-1].a, 3);
    chk("rstmf_new_data", wb_log[wb_log.size()-1].d, 99);

    // Randomized traffic, one offer per cycle.
    for (int k = 0; k < 400; k++) begin
      i_issue_valid = ($urandom_range(0, 3) != 0);
      i_opcode      = ($urandom_range(0, 7) == 0) ? 7'($urandom) :
                      (($urandom_range(0, 1) == 0) ? 7'o022 : 7'o023);
      i_ai          = 3'($urandom);
      i_aj          = 3'($urandom);
      i_ak          = 3'($urandom);
      i_Aj_val      = $urandom;
      i_Ak_val      = $urandom;
      i_ext_busy    = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      step(1);
    end
    idle();
    step(12);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
